// File: rtl/dino_game_pkg.sv
// Shared state encodings, pose codes, display register map and the
// score-dependent scroll speed rule for the dino game engine.
package dino_game_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_OVER = 2'd2;

   typedef enum logic [1:0] {
      POSE_RUN  = 2'd0,
      POSE_JUMP = 2'd1,
      POSE_DUCK = 2'd2
   } pose_t;

   localparam int WR_ADDR_W = 9;
   localparam int WR_DATA_W = 32;

   localparam logic [WR_ADDR_W-1:0] ADDR_DINO_Y   = 9'd1;
   localparam logic [WR_ADDR_W-1:0] ADDR_CACTUS_X = 9'd6;
   localparam logic [WR_ADDR_W-1:0] ADDR_SCORE    = 9'd10;

   localparam int DEF_DINO_X     = 100;
   localparam int DEF_GROUND_Y   = 168;
   localparam int DEF_JUMP_V0    = -12;
   localparam int DEF_SPAWN_X    = 620;
   localparam int DEF_HIT_MARGIN = 4;
   localparam int SPRITE_W       = 32;

   localparam logic [11:0] SCORE_MAX = 12'h999;

   // Scroll speed grows with the tens digit and caps at 6 px/frame from 40 on.
   function automatic logic [3:0] speed_for(input logic [3:0] hundreds,
                                            input logic [3:0] tens);
      if (hundreds != 4'd0 || tens >= 4'd4)
         return 4'd6;
      else
         return 4'd2 + tens;
   endfunction

endpackage

// File: rtl/dino_game_engine_if.sv
// Avalon-style write port from the game engine into the display register file.
interface dino_game_engine_if;
   import dino_game_pkg::*;

   logic                 wr_write;
   logic [WR_ADDR_W-1:0] wr_address;
   logic [WR_DATA_W-1:0] wr_writedata;
   logic                 wr_waitrequest;

   modport master (
      output wr_write,
      output wr_address,
      output wr_writedata,
      input  wr_waitrequest
   );

   modport slave (
      input  wr_write,
      input  wr_address,
      input  wr_writedata,
      output wr_waitrequest
   );

endinterface

// File: rtl/bcd_score_counter.sv
// Three-digit BCD score counter that sticks at 999; clear wins over inc.
module bcd_score_counter
   import dino_game_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        inc,
   output logic [11:0] bcd
);

   logic [11:0] bcd_q;
   logic [3:0]  d0;
   logic [3:0]  d1;
   logic [3:0]  d2;

   assign d0 = bcd_q[3:0];
   assign d1 = bcd_q[7:4];
   assign d2 = bcd_q[11:8];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bcd_q <= '0;
      end else if (clear) begin
         bcd_q <= '0;
      end else if (inc && bcd_q != SCORE_MAX) begin
         if (d0 != 4'd9) begin
            bcd_q[3:0] <= d0 + 4'd1;
         end else begin
            bcd_q[3:0] <= 4'd0;
            if (d1 != 4'd9) begin
               bcd_q[7:4] <= d1 + 4'd1;
            end else begin
               bcd_q[7:4]  <= 4'd0;
               bcd_q[11:8] <= d2 + 4'd1;
            end
         end
      end
   end

   assign bcd = bcd_q;

endmodule

// File: rtl/dino_game_engine.sv
// Per-frame dino game logic: jump physics, cactus scroll, BCD score, collision,
// followed by a three-beat register write burst into the display.
module dino_game_engine
   import dino_game_pkg::*;
#(
   parameter int DINO_X     = DEF_DINO_X,
   parameter int GROUND_Y   = DEF_GROUND_Y,
   parameter int JUMP_V0    = DEF_JUMP_V0,
   parameter int SPAWN_X    = DEF_SPAWN_X,
   parameter int HIT_MARGIN = DEF_HIT_MARGIN
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       frame_tick,
   input  logic                       start,
   input  logic                       jump,
   input  logic                       duck,
   dino_game_engine_if.master         wr,
   output logic [7:0]                 dino_y,
   output logic [9:0]                 cactus_x,
   output logic [11:0]                score_bcd,
   output logic [1:0]                 pose,
   output logic                       game_over
);

   localparam logic [7:0]        GROUND_Y_C = 8'(GROUND_Y);
   localparam logic signed [8:0] GROUND_S   = 9'(GROUND_Y);
   localparam logic [9:0]        SPAWN_X_C  = 10'(SPAWN_X);
   localparam logic signed [5:0] JUMP_V0_C  = 6'(JUMP_V0);
   localparam logic [10:0]       SPRITE_W11 = 11'(SPRITE_W);
   localparam logic [10:0]       HIT_RIGHT  = 11'(DINO_X + SPRITE_W - HIT_MARGIN);
   localparam logic [10:0]       HIT_LEFT   = 11'(DINO_X + HIT_MARGIN);
   localparam logic [10:0]       HIT_TOP    = 11'(GROUND_Y + HIT_MARGIN);

   function automatic logic [7:0] clamp_to_ground(input logic signed [8:0] y_raw);
      if (y_raw >= GROUND_S)
         return GROUND_Y_C;
      else
         return y_raw[7:0];
   endfunction

   logic [1:0]        state_q, state_n;
   logic [7:0]        dino_y_q, y_n;
   logic signed [5:0] vel_q, vel_n;
   logic              air_q, air_n;
   logic [9:0]        cactus_q, cx_n;
   logic [1:0]        pose_q, pose_n;
   logic              pending_q;
   logic              do_update;
   logic              sc_clear, sc_inc;
   logic signed [8:0] y_sum;
   logic [3:0]        spd;
   logic              hit;

   logic                 wr_write_q;
   logic [WR_ADDR_W-1:0] wr_addr_q;
   logic [WR_DATA_W-1:0] wr_data_q;
   logic [1:0]           beat_q;

   // A frame is processed only while the write port is quiet; a tick that
   // lands mid-burst is parked in pending_q and serviced right after.
   assign do_update = !wr_write_q && (frame_tick || pending_q);

   always_comb begin
      state_n  = state_q;
      y_n      = dino_y_q;
      vel_n    = vel_q;
      air_n    = air_q;
      cx_n     = cactus_q;
      pose_n   = pose_q;
      sc_clear = 1'b0;
      sc_inc   = 1'b0;
      y_sum    = '0;
      spd      = '0;
      hit      = 1'b0;
      if (state_q != ST_RUN) begin
         if (start) begin
            state_n  = ST_RUN;
            y_n      = GROUND_Y_C;
            vel_n    = '0;
            air_n    = 1'b0;
            cx_n     = SPAWN_X_C;
            sc_clear = 1'b1;
         end
      end else begin
         if (air_q) begin
            y_sum = $signed({1'b0, dino_y_q}) + $signed({{3{vel_q[5]}}, vel_q});
            vel_n = vel_q + 6'sd1;
            if (y_sum >= GROUND_S) begin
               air_n = 1'b0;
               vel_n = '0;
            end
            y_n = clamp_to_ground(y_sum);
         end else if (jump) begin
            air_n = 1'b1;
            vel_n = JUMP_V0_C;
         end
         pose_n = air_n ? POSE_JUMP : (duck ? POSE_DUCK : POSE_RUN);

         spd = speed_for(score_bcd[11:8], score_bcd[7:4]);
         if (cactus_q <= {6'd0, spd}) begin
            cx_n   = SPAWN_X_C;
            sc_inc = 1'b1;
         end else begin
            cx_n = cactus_q - {6'd0, spd};
         end

         // Shrunken boxes overlap horizontally and the dino is low enough to touch.
         hit = ({1'b0, cx_n} < HIT_RIGHT) &&
               (({1'b0, cx_n} + SPRITE_W11) > HIT_LEFT) &&
               (({3'b0, y_n} + SPRITE_W11) > HIT_TOP);
         if (hit)
            state_n = ST_OVER;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         dino_y_q  <= GROUND_Y_C;
         vel_q     <= '0;
         air_q     <= 1'b0;
         cactus_q  <= SPAWN_X_C;
         pose_q    <= POSE_RUN;
         pending_q <= 1'b0;
      end else begin
         if (do_update) begin
            state_q   <= state_n;
            dino_y_q  <= y_n;
            vel_q     <= vel_n;
            air_q     <= air_n;
            cactus_q  <= cx_n;
            pose_q    <= pose_n;
            pending_q <= 1'b0;
         end else if (frame_tick) begin
            pending_q <= 1'b1;
         end
      end
   end

   bcd_score_counter u_score (
      .clk   (clk),
      .reset (reset),
      .clear (do_update && sc_clear),
      .inc   (do_update && sc_inc),
      .bcd   (score_bcd)
   );

   // Beat 1 carries the freshly computed y; later beats read the registers,
   // which cannot change again until the burst has drained.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_write_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         beat_q     <= '0;
      end else if (do_update) begin
         wr_write_q <= 1'b1;
         wr_addr_q  <= ADDR_DINO_Y;
         wr_data_q  <= {24'd0, y_n};
         beat_q     <= 2'd0;
      end else if (wr_write_q && !wr.wr_waitrequest) begin
         case (beat_q)
            2'd0: begin
               wr_addr_q <= ADDR_CACTUS_X;
               wr_data_q <= {22'd0, cactus_q};
               beat_q    <= 2'd1;
            end
            2'd1: begin
               wr_addr_q <= ADDR_SCORE;
               wr_data_q <= {28'd0, score_bcd[3:0]};
               beat_q    <= 2'd2;
            end
            default: begin
               wr_write_q <= 1'b0;
               wr_addr_q  <= '0;
               wr_data_q  <= '0;
               beat_q     <= 2'd0;
            end
         endcase
      end
   end

   assign wr.wr_write     = wr_write_q;
   assign wr.wr_address   = wr_addr_q;
   assign wr.wr_writedata = wr_data_q;

   assign dino_y    = dino_y_q;
   assign cactus_x  = cactus_q;
   assign pose      = pose_q;
   assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_dino_game_engine.sv
// Scoreboard bench for dino_game_engine: a frame-level game model queues the
// expected write beats and a monitor compares them as the DUT emits them.
module tb_dino_game_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_tick;
   logic        start;
   logic        jump;
   logic        duck;
   logic [7:0]  dino_y;
   logic [9:0]  cactus_x;
   logic [11:0] score_bcd;
   logic [1:0]  pose;
   logic        game_over;

   dino_game_engine_if wr_bus ();

   dino_game_engine dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .start      (start),
      .jump       (jump),
      .duck       (duck),
      .wr         (wr_bus),
      .dino_y     (dino_y),
      .cactus_x   (cactus_x),
      .score_bcd  (score_bcd),
      .pose       (pose),
      .game_over  (game_over)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int data;
      bit chk;
      int y;
      int cx;
      int sc;
      int ps;
      int go;
   } beat_t;

   beat_t sb[$];

   int n_tests = 0;
   int n_fail  = 0;
   int wait_mode = 0;   // 0: never stall, 1: random stalls, 2: manual_wait
   bit manual_wait = 1'b0;

   // Game model: 0 idle, 1 run, 2 over; score kept as a plain decimal number.
   int m_state, m_y, m_vel, m_air, m_cx, m_score, m_pose;

   task automatic check(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int to_bcd(int s);
      return (s / 100) * 256 + ((s / 10) % 10) * 16 + (s % 10);
   endfunction

   function automatic void model_reset();
      m_state = 0; m_y = 168; m_vel = 0; m_air = 0;
      m_cx = 620; m_score = 0; m_pose = 0;
   endfunction

   function automatic void model_frame(bit st, bit jp, bit dk);
      beat_t b;
      int sp;
      int yn;
      if (m_state != 1) begin
         if (st) begin
            m_state = 1; m_y = 168; m_vel = 0; m_air = 0; m_cx = 620; m_score = 0;
         end
      end else begin
         if (m_air != 0) begin
            yn = m_y + m_vel;
            m_vel = m_vel + 1;
            if (yn >= 168) begin
               yn = 168; m_air = 0; m_vel = 0;
            end
            m_y = yn;
         end else if (jp) begin
            m_air = 1; m_vel = -12;
         end
         m_pose = (m_air != 0) ? 1 : (dk ? 2 : 0);
         sp = (m_score >= 100 || ((m_score / 10) % 10) >= 4) ? 6 : 2 + (m_score / 10) % 10;
         if (m_cx <= sp) begin
            m_cx = 620;
            if (m_score < 999) m_score = m_score + 1;
         end else begin
            m_cx = m_cx - sp;
         end
         if (m_cx < 128 && m_cx + 32 > 104 && m_y + 32 > 172) m_state = 2;
      end
      b.y = m_y; b.cx = m_cx; b.sc = to_bcd(m_score); b.ps = m_pose;
      b.go = (m_state == 2) ? 1 : 0;
      b.chk = 1'b1; b.addr = 1;  b.data = m_y;          sb.push_back(b);
      b.chk = 1'b0; b.addr = 6;  b.data = m_cx;         sb.push_back(b);
      b.chk = 1'b0; b.addr = 10; b.data = m_score % 10; sb.push_back(b);
   endfunction

   // Waitrequest driver, updated just after each rising edge.
   initial begin
      wr_bus.wr_waitrequest = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (wait_mode)
            1: wr_bus.wr_waitrequest = ($urandom_range(0, 3) == 0);
            2: wr_bus.wr_waitrequest = manual_wait;
            default: wr_bus.wr_waitrequest = 1'b0;
         endcase
      end
   end

   // Monitor: compares every presented beat against the queue head.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && wr_bus.wr_write) begin
            if (sb.size() == 0) begin
               check("unexpected_beat", int'(wr_bus.wr_write), 0);
            end else begin
               check("beat_addr", int'(wr_bus.wr_address), sb[0].addr);
               check("beat_data", int'(wr_bus.wr_writedata), sb[0].data);
               if (!wr_bus.wr_waitrequest) begin
                  if (sb[0].chk) begin
                     check("dino_y", int'(dino_y), sb[0].y);
                     check("cactus_x", int'(cactus_x), sb[0].cx);
                     check("score_bcd", int'(score_bcd), sb[0].sc);
                     check("pose", int'(pose), sb[0].ps);
                     check("game_over", int'(game_over), sb[0].go);
                  end
                  void'(sb.pop_front());
               end
            end
         end
      end
   end

   task automatic wait_idle(string name);
      bit done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (!wr_bus.wr_write && sb.size() == 0) done = 1'b1;
      end
      check(name, int'(done), 1);
   endtask

   task automatic do_tick(bit st, bit jp, bit dk);
      int len = 0;
      bit done = 1'b0;
      @(negedge clk);
      start = st; jump = jp; duck = dk; frame_tick = 1'b1;
      model_frame(st, jp, dk);
      @(posedge clk);
      #1 frame_tick = 1'b0;
      @(negedge clk);
      check("write_rise", int'(wr_bus.wr_write), 1);
      for (int i = 0; i < 400 && !done; i++) begin
         if (wr_bus.wr_write) len++;
         else if (sb.size() == 0) done = 1'b1;
         if (!done) @(negedge clk);
      end
      check("burst_done", int'(done), 1);
      if (wait_mode == 0) check("burst_len", len, 3);
   endtask

   initial begin
      reset = 1'b1; frame_tick = 1'b0; start = 1'b0; jump = 1'b0; duck = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_dino_y", int'(dino_y), 168);
      check("rst_cactus_x", int'(cactus_x), 620);
      check("rst_score", int'(score_bcd), 0);
      check("rst_pose", int'(pose), 0);
      check("rst_game_over", int'(game_over), 0);
      check("rst_wr_write", int'(wr_bus.wr_write), 0);
      check("rst_wr_address", int'(wr_bus.wr_address), 0);
      check("rst_wr_writedata", int'(wr_bus.wr_writedata), 0);
      reset = 1'b0;

      do_tick(0, 0, 0);
      do_tick(1, 0, 0);
      do_tick(0, 1, 0);
      for (int k = 1; k <= 25; k++) begin
         do_tick(0, 0, 0);
         if (k == 1) check("jump_t1", int'(dino_y), 156);
         if (k == 12 || k == 13) check("jump_apex", int'(dino_y), 90);
         if (k == 24) check("pose_t24", int'(pose), 1);
         if (k == 25) begin
            check("jump_land", int'(dino_y), 168);
            check("pose_t25", int'(pose), 0);
         end
      end

      for (int k = 0; k < 300 && !game_over; k++) do_tick(0, 0, 0);
      check("collide_over", int'(game_over), 1);
      check("collide_x", int'(cactus_x), 126);
      repeat (3) do_tick(0, 1, 1);
      check("frozen_y", int'(dino_y), 168);
      check("frozen_x", int'(cactus_x), 126);
      check("frozen_over", int'(game_over), 1);

      do_tick(1, 0, 0);
      @(negedge clk);
      force dut.u_score.bcd_q = 12'h039;
      force dut.cactus_q = 10'd2;
      #1;
      release dut.u_score.bcd_q;
      release dut.cactus_q;
      m_score = 39; m_cx = 2;
      do_tick(0, 0, 0);
      check("reload_score", int'(score_bcd), 'h040);
      check("reload_x", int'(cactus_x), 620);
      do_tick(0, 0, 0);
      check("speed6_x", int'(cactus_x), 614);

      @(negedge clk);
      force dut.u_score.bcd_q = 12'h999;
      force dut.cactus_q = 10'd2;
      #1;
      release dut.u_score.bcd_q;
      release dut.cactus_q;
      m_score = 999; m_cx = 2;
      do_tick(0, 0, 0);
      check("sat_score", int'(score_bcd), 'h999);
      check("sat_x", int'(cactus_x), 620);

      // Stall beat 2 for five cycles and tick during the stall.
      wait_mode = 2; manual_wait = 1'b0;
      @(negedge clk);
      start = 1'b0; jump = 1'b0; duck = 1'b0; frame_tick = 1'b1;
      model_frame(0, 0, 0);
      @(posedge clk);
      #1 frame_tick = 1'b0;
      @(negedge clk);
      manual_wait = 1'b1;
      @(negedge clk);
      check("stall_write", int'(wr_bus.wr_write), 1);
      check("stall_addr", int'(wr_bus.wr_address), 6);
      @(negedge clk);
      frame_tick = 1'b1;
      model_frame(0, 0, 0);
      @(posedge clk);
      #1 frame_tick = 1'b0;
      repeat (3) @(negedge clk);
      check("stall_held_addr", int'(wr_bus.wr_address), 6);
      check("stall_held_data", int'(wr_bus.wr_writedata), 614);
      manual_wait = 1'b0;
      wait_idle("pending_burst_done");
      check("pending_x", int'(cactus_x), 608);

      wait_mode = 1;
      for (int i = 0; i < 100; i++)
         do_tick($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      wait_mode = 0;

      // Asynchronous reset in the middle of a burst.
      @(negedge clk);
      start = 1'b1; jump = 1'b0; duck = 1'b0; frame_tick = 1'b1;
      model_frame(1, 0, 0);
      @(posedge clk);
      #1 frame_tick = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_wr_write", int'(wr_bus.wr_write), 0);
      check("midrst_dino_y", int'(dino_y), 168);
      check("midrst_cactus_x", int'(cactus_x), 620);
      check("midrst_score", int'(score_bcd), 0);
      check("midrst_pose", int'(pose), 0);
      check("midrst_game_over", int'(game_over), 0);
      sb.delete();
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      do_tick(0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
